// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: resets the PLL, waits for a stable lock, then releases the system reset.
// Define PLL_LOCK_GLITCH_FILTER_EN to ignore lock dropouts in RUN shorter than 4 cycles.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 24,
  parameter int LOCK_TIMEOUT   = 24000,
  parameter int STABLE_CYCLES  = 2400,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       i_xtal,
  input  logic       i_rst_n,
  input  logic       i_pll_lock,
  output logic       o_pll_resetb,
  output logic       o_sys_rst_n,
  output logic       o_ready,
  output logic       o_fail,
  output logic [7:0] o_lock_lost_cnt
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_ONE      = RTY_W'(1);
  localparam logic [RTY_W-1:0] RTY_LAST     = RTY_W'(MAX_RETRIES - 1);
`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam logic [CNT_W-1:0] GLITCH_LAST  = CNT_W'(3);
`endif

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  logic             sync1_q, lock_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge i_xtal or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= i_pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge i_xtal or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      lost_q       <= 8'd0;
      pll_resetb_q <= 1'b0;
      sys_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lost_q       <= lost_d;
      pll_resetb_q <= pll_resetb_d;
      sys_rst_n_q  <= sys_rst_n_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  // Next-state logic; lock_s edges win over any counter expiry on the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = '0;
          retry_d = retry_q + RTY_ONE;
          if (retry_q == RTY_LAST) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_PLL_RST;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
`ifdef PLL_LOCK_GLITCH_FILTER_EN
        if (lock_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == GLITCH_LAST) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
          lost_d  = (lost_q == 8'hFF) ? 8'hFF : lost_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        if (!lock_s_q) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
          lost_d  = (lost_q == 8'hFF) ? 8'hFF : lost_q + 8'd1;
        end else begin
          cnt_d = '0;
        end
`endif
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode of the next state so the output flops track the state register
  always_comb begin
    pll_resetb_d = 1'b0;
    sys_rst_n_d  = 1'b0;
    ready_d      = 1'b0;
    fail_d       = 1'b0;
    case (state_d)
      ST_PLL_RST: begin
        pll_resetb_d = 1'b0;
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        pll_resetb_d = 1'b1;
      end
      ST_RUN: begin
        pll_resetb_d = 1'b1;
        sys_rst_n_d  = 1'b1;
        ready_d      = 1'b1;
      end
      ST_FAIL: begin
        fail_d = 1'b1;
      end
      default: begin
        pll_resetb_d = 1'b0;
      end
    endcase
  end

  assign o_pll_resetb    = pll_resetb_q;
  assign o_sys_rst_n     = sys_rst_n_q;
  assign o_ready         = ready_q;
  assign o_fail          = fail_q;
  assign o_lock_lost_cnt = lost_q;

endmodule
